// File: rtl/cpu_mem_bridge_if.sv
// Memory-side port of the CPU/memory bridge.
// Handshake: the bridge raises mem_req together with mem_we/mem_addr/mem_wdata
// and holds all four stable until a cycle in which the memory drives
// mem_ready=1. That cycle completes the access, and for reads mem_rdata is valid
// in it. A mem_ready seen while mem_req=0 has no meaning and is ignored.
interface cpu_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Serialises the CPU's instruction and data ports onto one memory port.
// Both requests of a CPU cycle are latched in IDLE, served one after the other
// (DM first when DM_FIRST=1), and stall is held until both have completed.
// An access that waits MAX_WAIT cycles without mem_ready is abandoned and the
// sticky timeout flag is raised.
module cpu_mem_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255,
    parameter int DM_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IM_enable,
    input  logic [ADDR_W-1:0] IM_address,
    output logic [DATA_W-1:0] IM_out,
    input  logic              DM_enable,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    output logic [DATA_W-1:0] DM_out,
    output logic              stall,
    output logic              timeout,
    output logic [1:0]        dbg_state,
    cpu_mem_bridge_if.master  mem
);
    // Counter only ever holds 0..MAX_WAIT-1, so this width never wraps.
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_A = 2'd1,
        ACC_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;

    // Request snapshot taken in IDLE; CPU inputs are ignored after that.
    logic              both_q;
    logic              cur_dm;
    logic [ADDR_W-1:0] im_addr_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic              dm_we_q;
    logic [DATA_W-1:0] dm_wdata_q;

    logic start;
    logic acc_end;
    logic wait_expired;
    logic load_second;
    logic first_dm;

    assign first_dm  = DM_enable && ((DM_FIRST != 0) || !IM_enable);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode, stall, and the per-cycle control strobes.
    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        start        = 1'b0;
        acc_end      = 1'b0;
        wait_expired = 1'b0;
        load_second  = 1'b0;
        case (state)
            IDLE: begin
                stall = IM_enable | DM_enable;
                if (IM_enable | DM_enable) begin
                    start      = 1'b1;
                    state_next = ACC_A;
                end
            end
            ACC_A, ACC_B: begin
                stall        = 1'b1;
                wait_expired = !mem.mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
                if (mem.mem_ready || wait_expired) begin
                    acc_end     = 1'b1;
                    load_second = (state == ACC_A) && both_q;
                    state_next  = load_second ? ACC_B : DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory port drive, read-data capture and wait counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            IM_out        <= '0;
            DM_out        <= '0;
            timeout       <= 1'b0;
            wait_cnt      <= '0;
            both_q        <= 1'b0;
            cur_dm        <= 1'b0;
            im_addr_q     <= '0;
            dm_addr_q     <= '0;
            dm_we_q       <= 1'b0;
            dm_wdata_q    <= '0;
        end else if (start) begin
            im_addr_q     <= IM_address;
            dm_addr_q     <= DM_address;
            dm_we_q       <= DM_write;
            dm_wdata_q    <= DM_in;
            both_q        <= IM_enable & DM_enable;
            cur_dm        <= first_dm;
            mem.mem_req   <= 1'b1;
            mem.mem_addr  <= first_dm ? DM_address : IM_address;
            mem.mem_we    <= first_dm & DM_write;
            mem.mem_wdata <= first_dm ? DM_in : '0;
            wait_cnt      <= '0;
        end else if (acc_end) begin
            wait_cnt <= '0;
            if (wait_expired) begin
                timeout <= 1'b1;
            end else if (!mem.mem_we) begin
                if (cur_dm) DM_out <= mem.mem_rdata;
                else        IM_out <= mem.mem_rdata;
            end
            if (load_second) begin
                // mem_req stays high: the second access follows back-to-back.
                cur_dm        <= !cur_dm;
                mem.mem_addr  <= cur_dm ? im_addr_q : dm_addr_q;
                mem.mem_we    <= !cur_dm & dm_we_q;
                mem.mem_wdata <= cur_dm ? '0 : dm_wdata_q;
            end else begin
                mem.mem_req <= 1'b0;
                mem.mem_we  <= 1'b0;
            end
        end else if (state == ACC_A || state == ACC_B) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge. A bench-side memory answers each
// request after a chosen delay; a transaction-level model predicts the access
// order, stall length, read data and timeout flag for every CPU request.
module tb_cpu_mem_bridge;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          IM_enable;
    logic [AW-1:0] IM_address;
    logic [DW-1:0] IM_out;
    logic          DM_enable;
    logic          DM_write;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DM_in;
    logic [DW-1:0] DM_out;
    logic          stall;
    logic          timeout;
    logic [1:0]    dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // Memory contents and model of the bridge's architectural outputs.
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [DW-1:0] im_m;
    logic [DW-1:0] dm_m;
    logic          to_m;

    cpu_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    cpu_mem_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .DM_FIRST(1)
    ) dut (
        .clk(clk), .rst(rst),
        .IM_enable(IM_enable), .IM_address(IM_address), .IM_out(IM_out),
        .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out),
        .stall(stall), .timeout(timeout), .dbg_state(dbg_state),
        .mem(mem_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // One CPU request. d_im/d_dm: cycles before mem_ready (>= MAXW means never).
    task automatic run_txn(input bit im_en, input bit dm_en, input bit dm_we,
                           input logic [AW-1:0] im_a, input logic [AW-1:0] dm_a,
                           input logic [DW-1:0] dm_d, input int d_im, input int d_dm,
                           input bit scramble);
        logic [AW+DW:0] exp_q[$];
        int             dly_q[$];
        int             exp_stall;
        logic [DW-1:0]  exp_im;
        logic [DW-1:0]  exp_dm;
        logic [AW+DW:0] cur;
        int             stall_cnt;
        int             req_cycle;
        int             cyc;
        bit             done;

        exp_stall = 1;
        exp_im    = im_m;
        exp_dm    = dm_m;
        if (dm_en) begin
            exp_q.push_back({dm_we, dm_a, (dm_we ? dm_d : {DW{1'b0}})});
            dly_q.push_back(d_dm);
            exp_stall += (d_dm < MAXW) ? d_dm + 1 : MAXW;
            if (d_dm >= MAXW) to_m = 1'b1;
            else if (!dm_we)  exp_dm = mem_read(dm_a);
        end
        if (im_en) begin
            exp_q.push_back({1'b0, im_a, {DW{1'b0}}});
            dly_q.push_back(d_im);
            exp_stall += (d_im < MAXW) ? d_im + 1 : MAXW;
            if (d_im >= MAXW) to_m = 1'b1;
            else              exp_im = mem_read(im_a);
        end

        IM_enable  = im_en;
        IM_address = im_a;
        DM_enable  = dm_en;
        DM_write   = dm_we;
        DM_address = dm_a;
        DM_in      = dm_d;
        stall_cnt  = 0;
        req_cycle  = 0;
        cyc        = 0;
        done       = 1'b0;
        while (!done && cyc < 64) begin
            #1;
            if (stall !== 1'b1) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                mem_bus.mem_ready = 1'b0;
                mem_bus.mem_rdata = $urandom();
                if (mem_bus.mem_req === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_access: addr %h we %b, no access expected", mem_bus.mem_addr, mem_bus.mem_we);
                    end else begin
                        cur = exp_q[0];
                        if (mem_bus.mem_we !== cur[AW+DW] || mem_bus.mem_addr !== cur[AW+DW-1:DW] ||
                            (cur[AW+DW] && mem_bus.mem_wdata !== cur[DW-1:0])) begin
                            miscompares++;
                            $display("FAIL access: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                                     mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                                     cur[AW+DW], cur[AW+DW-1:DW], cur[DW-1:0]);
                        end
                        if (dly_q[0] < MAXW && req_cycle == dly_q[0]) begin
                            mem_bus.mem_ready = 1'b1;
                            if (mem_bus.mem_we === 1'b1) mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
                            else                          mem_bus.mem_rdata = mem_read(mem_bus.mem_addr);
                            void'(exp_q.pop_front());
                            void'(dly_q.pop_front());
                            req_cycle = 0;
                        end else if (req_cycle == MAXW - 1) begin
                            void'(exp_q.pop_front());
                            void'(dly_q.pop_front());
                            req_cycle = 0;
                        end else begin
                            req_cycle++;
                        end
                    end
                end
                if (scramble && cyc > 0) begin
                    IM_enable  = 1'($urandom_range(0, 1));
                    DM_enable  = 1'($urandom_range(0, 1));
                    DM_write   = 1'($urandom_range(0, 1));
                    IM_address = $urandom();
                    DM_address = $urandom();
                    DM_in      = $urandom();
                end
                @(negedge clk);
                cyc++;
            end
        end
        IM_enable         = 1'b0;
        DM_enable         = 1'b0;
        mem_bus.mem_ready = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL txn_bound: stall still high after %0d cycles (state %0d)", cyc, dbg_state);
        end
        vectors++;
        if (stall_cnt != exp_stall) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cnt, exp_stall);
        end
        vectors++;
        if (mem_bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL req_in_done: got %b expected 0", mem_bus.mem_req);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_access: got %0d pending, expected 0", exp_q.size());
        end
        vectors++;
        if (IM_out !== exp_im) begin
            miscompares++;
            $display("FAIL im_out: got %h expected %h", IM_out, exp_im);
        end
        vectors++;
        if (DM_out !== exp_dm) begin
            miscompares++;
            $display("FAIL dm_out: got %h expected %h", DM_out, exp_dm);
        end
        vectors++;
        if (timeout !== to_m) begin
            miscompares++;
            $display("FAIL timeout_flag: got %b expected %b", timeout, to_m);
        end
        im_m = exp_im;
        dm_m = exp_dm;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        IM_enable         = 1'b0;
        IM_address        = '0;
        DM_enable         = 1'b0;
        DM_write          = 1'b0;
        DM_address        = '0;
        DM_in             = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (IM_out !== '0 || DM_out !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got IM_out=%h DM_out=%h expected 0", IM_out, DM_out);
        end
        vectors++;
        if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0 ||
            mem_bus.mem_addr !== '0 || mem_bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h expected all 0",
                     mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        vectors++;
        if (timeout !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got timeout=%b stall=%b expected 0", timeout, stall);
        end
        rst  = 1'b0;
        im_m = '0;
        dm_m = '0;
        to_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        IM_enable  = 1'b1;
        IM_address = 32'h40;
        DM_enable  = 1'b1;
        DM_write   = 1'b0;
        DM_address = 32'h100;
        @(negedge clk);
        #1;
        vectors++;
        if (mem_bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_req_active: got %b expected 1", mem_bus.mem_req);
        end
        rst               = 1'b1;
        IM_enable         = 1'b0;
        DM_enable         = 1'b0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        vectors++;
        if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_req_drop: got req=%b stall=%b expected 0", mem_bus.mem_req, stall);
        end
        rst = 1'b0;
        repeat (3) begin
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_rdata = $urandom();
            @(negedge clk);
            #1;
            vectors++;
            if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0 || IM_out !== '0 || DM_out !== '0) begin
                miscompares++;
                $display("FAIL late_ready: got req=%b stall=%b IM_out=%h DM_out=%h expected all 0",
                         mem_bus.mem_req, stall, IM_out, DM_out);
            end
        end
        mem_bus.mem_ready = 1'b0;
        im_m = '0;
        dm_m = '0;
        to_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_latency();
        mem_model[32'h100] = 32'hDEAD_BEEF;
        run_txn(1'b0, 1'b1, 1'b0, '0, 32'h100, '0, 0, 2, 1'b0);
        #1;
        vectors++;
        if (DM_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_value: got %h expected deadbeef", DM_out);
        end
    endtask

    task automatic test_both_enabled();
        run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h1100, '0, 0, 0, 1'b0);
    endtask

    task automatic test_store();
        run_txn(1'b0, 1'b1, 1'b1, '0, 32'h20, 32'h1234, 0, 3, 1'b0);
        vectors++;
        if (mem_read(32'h20) !== 32'h1234) begin
            miscompares++;
            $display("FAIL store_data: memory holds %h expected 00001234", mem_read(32'h20));
        end
    endtask

    task automatic test_addr_change();
        run_txn(1'b0, 1'b1, 1'b0, '0, 32'h200, '0, 0, 3, 1'b1);
    endtask

    task automatic test_random();
        bit            im_en;
        bit            dm_en;
        logic [AW-1:0] im_a;
        logic [AW-1:0] dm_a;
        int            d_im;
        int            d_dm;
        int            gap;
        for (int n = 0; n < 30; n++) begin
            im_en = 1'($urandom_range(0, 1));
            dm_en = 1'($urandom_range(0, 1));
            if (!im_en && !dm_en) dm_en = 1'b1;
            im_a = AW'(4 * $urandom_range(0, 63));
            dm_a = AW'(32'h1000 + 4 * $urandom_range(0, 15));
            d_im = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 4));
            d_dm = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 4));
            run_txn(im_en, dm_en, 1'($urandom_range(0, 1)), im_a, dm_a, $urandom(),
                    d_im, d_dm, 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = $urandom();
                #1;
                vectors++;
                if (stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_quiet: got stall=%b req=%b expected 0", stall, mem_bus.mem_req);
                end
                @(negedge clk);
            end
            mem_bus.mem_ready = 1'b0;
            #1;
            vectors++;
            if (IM_out !== im_m || DM_out !== dm_m) begin
                miscompares++;
                $display("FAIL idle_hold: got IM_out=%h DM_out=%h expected %h %h", IM_out, DM_out, im_m, dm_m);
            end
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        im_m = '0;
        dm_m = '0;
        to_m = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 1'b1, 1'b0, '0, 32'h1000, '0, 0, 20, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h80, 32'h1004, '0, 1, 20, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 32'hC0, '0, '0, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got %b expected 0", timeout);
        end
        to_m = 1'b0;
        im_m = '0;
        dm_m = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_load_latency();
        test_both_enabled();
        test_store();
        test_addr_change();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
